// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Parses the UART byte stream into SYNC, LEN, payload, CHK frames. Payload
// bytes are written cut-through to the RX FIFO, and every frame ends with a
// single-cycle done or error pulse so downstream logic can commit or discard.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 8700,
    parameter int         TO_W         = 14
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    input  logic       i_Fifo_Full,
    output logic       o_Fifo_Wr_En,
    output logic [7:0] o_Fifo_Wr_Data,
    output logic       o_Frame_Done,
    output logic       o_Frame_Err,
    output logic [2:0] o_Err_Code,
    output logic [7:0] o_Frame_Len,
    output logic       o_Busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LEN     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_CHK     = 2'd3;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_CHECKSUM = 3'd1;
    localparam logic [2:0] ERR_LENGTH   = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
    localparam logic [2:0] ERR_OVERFLOW = 3'd4;

    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);

    logic [1:0]      state_q,    state_d;
    logic [7:0]      len_q,      len_d;
    logic [7:0]      remain_q,   remain_d;
    logic [7:0]      xor_q,      xor_d;
    logic            ovf_q,      ovf_d;
    logic [TO_W-1:0] toCnt_q,    toCnt_d;
    logic            wrEn_q,     wrEn_d;
    logic [7:0]      wrData_q,   wrData_d;
    logic            done_q,     done_d;
    logic            err_q,      err_d;
    logic [2:0]      errCode_q,  errCode_d;
    logic [7:0]      frameLen_q, frameLen_d;

    // Next-state logic: frame parsing on byte strobes, plus the inter-byte timeout.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        remain_d   = remain_q;
        xor_d      = xor_q;
        ovf_d      = ovf_q;
        toCnt_d    = toCnt_q;
        wrEn_d     = 1'b0;
        wrData_d   = wrData_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        errCode_d  = errCode_q;
        frameLen_d = frameLen_q;

        // The timeout only runs inside a frame; any byte restarts it and it
        // never counts past the expiry value.
        if (state_q == ST_IDLE || i_Rx_DV) begin
            toCnt_d = '0;
        end else if (toCnt_q != TO_LAST) begin
            toCnt_d = toCnt_q + TO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == 8'h00 || i_Rx_Byte > MAX_LEN_B) begin
                        err_d     = 1'b1;
                        errCode_d = ERR_LENGTH;
                        state_d   = ST_IDLE;
                    end else begin
                        len_d    = i_Rx_Byte;
                        remain_d = i_Rx_Byte;
                        xor_d    = i_Rx_Byte;
                        ovf_d    = 1'b0;
                        state_d  = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (i_Rx_DV) begin
                    xor_d    = xor_q ^ i_Rx_Byte;
                    remain_d = remain_q - 8'd1;
                    if (!i_Fifo_Full) begin
                        wrEn_d   = 1'b1;
                        wrData_d = i_Rx_Byte;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (remain_q == 8'd1) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (i_Rx_DV) begin
                    if (ovf_q) begin
                        err_d     = 1'b1;
                        errCode_d = ERR_OVERFLOW;
                    end else if (i_Rx_Byte == xor_q) begin
                        done_d     = 1'b1;
                        errCode_d  = ERR_NONE;
                        frameLen_d = len_q;
                    end else begin
                        err_d     = 1'b1;
                        errCode_d = ERR_CHECKSUM;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A byte landing on the expiry cycle wins, so expiry needs a quiet cycle.
        if (state_q != ST_IDLE && !i_Rx_DV && toCnt_q == TO_LAST) begin
            err_d     = 1'b1;
            errCode_d = ERR_TIMEOUT;
            state_d   = ST_IDLE;
            toCnt_d   = '0;
        end
    end

    // State and output registers; reset abandons any frame without a pulse.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            remain_q   <= '0;
            xor_q      <= '0;
            ovf_q      <= 1'b0;
            toCnt_q    <= '0;
            wrEn_q     <= 1'b0;
            wrData_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            errCode_q  <= ERR_NONE;
            frameLen_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            remain_q   <= remain_d;
            xor_q      <= xor_d;
            ovf_q      <= ovf_d;
            toCnt_q    <= toCnt_d;
            wrEn_q     <= wrEn_d;
            wrData_q   <= wrData_d;
            done_q     <= done_d;
            err_q      <= err_d;
            errCode_q  <= errCode_d;
            frameLen_q <= frameLen_d;
        end
    end

    assign o_Fifo_Wr_En   = wrEn_q;
    assign o_Fifo_Wr_Data = wrData_q;
    assign o_Frame_Done   = done_q;
    assign o_Frame_Err    = err_q;
    assign o_Err_Code     = errCode_q;
    assign o_Frame_Len    = frameLen_q;
    assign o_Busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl
// Table of frames driven into the frame controller, with FIFO writes and
// frame-end pulses checked against a scoreboard keyed by clock cycle.
module tb_uart_rx_frame_ctrl;

    localparam int         T    = 8700;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clock = 1'b0;
    logic       rstN;
    logic       rxDv;
    logic [7:0] rxByte;
    logic       fifoFull;
    logic       fifoWrEn;
    logic [7:0] fifoWrData;
    logic       frameDone;
    logic       frameErr;
    logic [2:0] errCode;
    logic [7:0] frameLen;
    logic       busy;

    uart_rx_frame_ctrl #(
        .SYNC_BYTE   (SYNC),
        .MAX_LEN     (16),
        .TIMEOUT_CLKS(T),
        .TO_W        (14)
    ) dut (
        .i_Clock       (clock),
        .i_Rst_n       (rstN),
        .i_Rx_DV       (rxDv),
        .i_Rx_Byte     (rxByte),
        .i_Fifo_Full   (fifoFull),
        .o_Fifo_Wr_En  (fifoWrEn),
        .o_Fifo_Wr_Data(fifoWrData),
        .o_Frame_Done  (frameDone),
        .o_Frame_Err   (frameErr),
        .o_Err_Code    (errCode),
        .o_Frame_Len   (frameLen),
        .o_Busy        (busy)
    );

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } wrExp_t;

    typedef struct {
        int         cyc;
        bit         isDone;
        logic [2:0] code;
        logic [7:0] len;
    } endExp_t;

    typedef struct {
        string            name;
        logic [7:0]       lenByte;
        logic [15:0][7:0] payload;
        logic [15:0]      fullMask;
        bit               corruptChk;
        bit               preNoise;
        bit               expDone;
        logic [2:0]       expCode;
    } frameVec_t;

    wrExp_t     wrQ[$];
    endExp_t    endQ[$];
    frameVec_t  vecs[$];
    int         cycCnt = 0;
    int         nChecks = 0;
    int         nFails = 0;
    logic [7:0] lastLen = 8'h00;

    // Free-running clock.
    always #5 clock = ~clock;

    // Cycle index used to time-stamp expected events.
    always @(posedge clock) cycCnt <= cycCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycCnt);
        end
    endtask

    // Drives one byte strobe for one cycle; returns the edge that samples it.
    task automatic applyStimulus(input logic [7:0] b, input logic full, output int sampleCyc);
        rxDv      = 1'b1;
        rxByte    = b;
        fifoFull  = full;
        sampleCyc = cycCnt + 1;
        @(posedge clock);
        #1;
        rxDv     = 1'b0;
        fifoFull = 1'b0;
    endtask

    task automatic applyAt(input int target, input logic [7:0] b, output int sampleCyc);
        while (cycCnt + 1 < target) begin
            @(posedge clock);
            #1;
        end
        applyStimulus(b, 1'b0, sampleCyc);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pushEnd(input int cyc, input bit isDone, input logic [2:0] code, input logic [7:0] len);
        if (isDone) lastLen = len;
        endQ.push_back('{cyc, isDone, code, lastLen});
    endtask

    function automatic frameVec_t mkVec(input string name, input logic [7:0] lenByte, input logic [127:0] pay,
                                        input logic [15:0] mask, input bit corrupt, input bit noise,
                                        input bit expDone, input logic [2:0] expCode);
        frameVec_t v;
        v.name       = name;
        v.lenByte    = lenByte;
        v.payload    = pay;
        v.fullMask   = mask;
        v.corruptChk = corrupt;
        v.preNoise   = noise;
        v.expDone    = expDone;
        v.expCode    = expCode;
        return v;
    endfunction

    // Sends one table frame and records the writes and frame end it should produce.
    task automatic runFrame(input frameVec_t v);
        int         s;
        logic [7:0] x;
        if (v.preNoise) begin
            applyStimulus(8'h00, 1'b0, s);
            applyStimulus(8'hFF, 1'b0, s);
        end
        applyStimulus(SYNC, 1'b0, s);
        applyStimulus(v.lenByte, 1'b0, s);
        if (v.expCode == 3'd2) begin
            pushEnd(s, 1'b0, 3'd2, 8'h00);
        end else begin
            x = v.lenByte;
            for (int i = 0; i < int'(v.lenByte); i++) begin
                applyStimulus(v.payload[i], v.fullMask[i], s);
                x = x ^ v.payload[i];
                if (!v.fullMask[i]) wrQ.push_back('{s, v.payload[i]});
            end
            applyStimulus(v.corruptChk ? (x ^ 8'h01) : x, 1'b0, s);
            pushEnd(s, v.expDone, v.expCode, v.lenByte);
        end
        idleCycles(3);
    endtask

    // Scoreboard: compares every FIFO write and frame-end pulse with the queues.
    always @(negedge clock) begin
        if (rstN) begin
            while (wrQ.size() > 0 && wrQ[0].cyc < cycCnt) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL missed write: data %0h due at cycle %0d never seen", wrQ[0].data, wrQ[0].cyc);
                void'(wrQ.pop_front());
            end
            while (endQ.size() > 0 && endQ[0].cyc < cycCnt) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL missed frame end: pulse due at cycle %0d never seen", endQ[0].cyc);
                void'(endQ.pop_front());
            end
            if (fifoWrEn) begin
                if (wrQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected write: got data %0h, expected no write (cycle %0d)", fifoWrData, cycCnt);
                end else begin
                    wrExp_t e;
                    e = wrQ.pop_front();
                    checkOutput("write cycle", cycCnt, e.cyc);
                    checkOutput("write data", fifoWrData, e.data);
                end
            end
            if (frameDone || frameErr) begin
                checkOutput("done/err exclusive", {31'd0, frameDone & frameErr}, 32'd0);
                checkOutput("busy at frame end", {31'd0, busy}, 32'd0);
                if (endQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected frame end: got done=%0b err=%0b code=%0d, expected none (cycle %0d)",
                             frameDone, frameErr, errCode, cycCnt);
                end else begin
                    endExp_t e;
                    e = endQ.pop_front();
                    checkOutput("end cycle", cycCnt, e.cyc);
                    checkOutput("frame done", {31'd0, frameDone}, {31'd0, e.isDone});
                    checkOutput("frame err", {31'd0, frameErr}, {31'd0, !e.isDone});
                    checkOutput("err code", {29'd0, errCode}, {29'd0, e.code});
                    checkOutput("frame len", {24'd0, frameLen}, {24'd0, e.len});
                end
            end
        end
    end

    // Guard against a hung run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main stimulus: reset, frame table, timeout, expiry race, mid-frame reset.
    initial begin
        int s;
        int s2;
        rstN     = 1'b1;
        rxDv     = 1'b0;
        rxByte   = 8'h00;
        fifoFull = 1'b0;
        #1 rstN  = 1'b0;
        #2;
        checkOutput("reset wr_en", {31'd0, fifoWrEn}, 32'd0);
        checkOutput("reset done", {31'd0, frameDone}, 32'd0);
        checkOutput("reset err", {31'd0, frameErr}, 32'd0);
        checkOutput("reset code", {29'd0, errCode}, 32'd0);
        checkOutput("reset len", {24'd0, frameLen}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        #19 rstN = 1'b1;
        @(posedge clock);
        #1;

        vecs.push_back(mkVec("good", 8'h03, 128'h332211, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd0));
        vecs.push_back(mkVec("bad checksum", 8'h03, 128'h332211, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd1));
        vecs.push_back(mkVec("good after error", 8'h02, 128'hC35A, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd0));
        vecs.push_back(mkVec("len zero", 8'h00, 128'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd2));
        vecs.push_back(mkVec("len too big", 8'h11, 128'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd2));
        vecs.push_back(mkVec("overflow", 8'h03, 128'h332211, 16'h0002, 1'b0, 1'b0, 1'b0, 3'd4));
        vecs.push_back(mkVec("noise and sync data", 8'h01, 128'hA5, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd0));
        vecs.push_back(mkVec("max length", 8'h10, 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 16'h0000,
                             1'b0, 1'b0, 1'b1, 3'd0));
        vecs.push_back(mkVec("overflow beats checksum", 8'h02, 128'h0201, 16'h0002, 1'b1, 1'b0, 1'b0, 3'd4));

        foreach (vecs[i]) begin
            $display("[TB] frame %0d: %s", i, vecs[i].name);
            runFrame(vecs[i]);
        end

        // Silence after a payload byte must expire exactly T cycles later.
        $display("[TB] timeout");
        applyStimulus(SYNC, 1'b0, s);
        applyStimulus(8'h02, 1'b0, s);
        applyStimulus(8'h11, 1'b0, s);
        wrQ.push_back('{s, 8'h11});
        pushEnd(s + T, 1'b0, 3'd3, 8'h00);
        idleCycles(T + 5);
        checkOutput("code held after timeout", {29'd0, errCode}, 32'd3);
        checkOutput("idle after timeout", {31'd0, busy}, 32'd0);

        // A byte landing on the expiry cycle keeps the frame alive.
        $display("[TB] byte on expiry cycle");
        applyStimulus(SYNC, 1'b0, s);
        checkOutput("busy inside frame", {31'd0, busy}, 32'd1);
        applyStimulus(8'h02, 1'b0, s);
        applyStimulus(8'h11, 1'b0, s);
        wrQ.push_back('{s, 8'h11});
        applyAt(s + T, 8'h22, s2);
        wrQ.push_back('{s2, 8'h22});
        applyStimulus(8'h31, 1'b0, s);
        pushEnd(s, 1'b1, 3'd0, 8'h02);
        idleCycles(4);

        // Reset mid-frame clears outputs at once and leaves no pulse behind.
        $display("[TB] reset mid-frame");
        applyStimulus(SYNC, 1'b0, s);
        applyStimulus(8'h02, 1'b0, s);
        applyStimulus(8'h11, 1'b0, s);
        wrQ.push_back('{s, 8'h11});
        idleCycles(2);
        #2 rstN = 1'b0;
        #1;
        lastLen = 8'h00;
        checkOutput("mid reset wr_en", {31'd0, fifoWrEn}, 32'd0);
        checkOutput("mid reset wr_data", {24'd0, fifoWrData}, 32'd0);
        checkOutput("mid reset done", {31'd0, frameDone}, 32'd0);
        checkOutput("mid reset err", {31'd0, frameErr}, 32'd0);
        checkOutput("mid reset len", {24'd0, frameLen}, 32'd0);
        checkOutput("mid reset busy", {31'd0, busy}, 32'd0);
        #20 rstN = 1'b1;
        @(posedge clock);
        #1;
        runFrame(mkVec("after reset", 8'h02, 128'h2211, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd0));

        idleCycles(5);
        checkOutput("write queue drained", wrQ.size(), 32'd0);
        checkOutput("end queue drained", endQ.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
